// File: rtl/mac_pkg.sv
// Shared definitions for the 2-bit multiply-accumulate stage.
package mac_pkg;

  localparam int unsigned PROD_W    = 4;
  localparam int unsigned DEF_LEN   = 4;
  localparam int unsigned DEF_ACC_W = 8;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/multiplier_2bit.sv
// 2-bit x 2-bit unsigned multiplier, 4-bit product (0..9).
module multiplier_2bit (
  input  logic [1:0] i1,
  input  logic [1:0] i2,
  output logic [3:0] out
);

  assign out = {2'b00, i1} * {2'b00, i2};

endmodule

// File: rtl/mac_2bit_accumulator.sv
// Sequential dot-product stage: multiplies 2-bit operand pairs and
// accumulates LEN products into a saturating ACC_W-bit sum.
module mac_2bit_accumulator
  import mac_pkg::*;
#(
  parameter int unsigned LEN   = DEF_LEN,
  parameter int unsigned ACC_W = DEF_ACC_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       a,
  input  logic [1:0]       b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] result,
  output logic             ovf,
  output logic             busy
);

  localparam int unsigned        CNT_W = $clog2(LEN + 1);
  localparam logic [CNT_W-1:0]   LAST  = CNT_W'(LEN - 1);

  state_t             state_q;
  logic [ACC_W-1:0]   acc_q;
  logic [ACC_W-1:0]   acc_d;
  logic [CNT_W-1:0]   cnt_q;
  logic               ovf_q;
  logic               ovf_d;
  logic               in_ready_q;
  logic               out_valid_q;
  logic               busy_q;
  logic [PROD_W-1:0]  prod;
  logic [ACC_W:0]     sum;

  multiplier_2bit u_mult (
    .i1  (a),
    .i2  (b),
    .out (prod)
  );

  // Saturating add of the current product onto the accumulator.
  always_comb begin
    sum   = {1'b0, acc_q} + (ACC_W + 1)'(prod);
    acc_d = sum[ACC_W] ? '1 : sum[ACC_W-1:0];
    ovf_d = ovf_q | sum[ACC_W];
  end

  // Control FSM and accumulator; handshake flags are registered alongside
  // the state so they always match the state they decode.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            acc_q      <= '0;
            cnt_q      <= '0;
            ovf_q      <= 1'b0;
            state_q    <= S_ACCUM;
            in_ready_q <= 1'b1;
            busy_q     <= 1'b1;
          end
        end
        S_ACCUM: begin
          if (start) begin
            // restart: start wins over any beat offered this cycle
            acc_q <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
          end else if (in_valid && in_ready_q) begin
            acc_q <= acc_d;
            ovf_q <= ovf_d;
            cnt_q <= cnt_q + CNT_W'(1);
            if (cnt_q == LAST) begin
              state_q     <= S_DONE;
              in_ready_q  <= 1'b0;
              out_valid_q <= 1'b1;
            end
          end
        end
        S_DONE: begin
          if (out_ready) begin
            state_q     <= S_IDLE;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
          end
        end
        default: begin
          state_q     <= S_IDLE;
          in_ready_q  <= 1'b0;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign result    = acc_q;
  assign ovf       = ovf_q;

endmodule
